// File: rtl/idct_1d.sv
// idct_1d: streaming 8-point 1-D inverse DCT (orthonormal DCT-III, Q1.14 constants).
// Ports:
//   clk       - rising-edge clock
//   rst       - asynchronous active-high reset
//   ena_in    - S_in is valid and consumed on this edge
//   S_in      - coefficient X[k], k = 0..7 in natural order
//   out_valid - S_out carries a sample
//   out_first - high with out_valid when S_out is x[0]
//   S_out     - reconstructed sample x[n], rounded and saturated
module idct_1d #(
    parameter int W_IN  = 12,
    parameter int W_OUT = 8,
    parameter int W_C   = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ena_in,
    input  logic signed [W_IN-1:0]  S_in,
    output logic                    out_valid,
    output logic                    out_first,
    output logic signed [W_OUT-1:0] S_out
);
    localparam int W_ACC = W_IN + W_C + 3;
    localparam logic signed [W_ACC-1:0] hi_lim = W_ACC'((1 << (W_OUT - 1)) - 1);
    localparam logic signed [W_ACC-1:0] lo_lim = W_ACC'(-(1 << (W_OUT - 1)));

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state;
    logic [2:0]              in_cnt;
    logic [2:0]              n;
    logic                    copied;
    logic                    take;
    logic                    last;
    logic signed [W_IN-1:0]  col  [8];
    logic signed [W_IN-1:0]  work [8];
    logic signed [W_IN-1:0]  cur  [8];
    logic signed [W_ACC-1:0] acc;
    logic signed [W_ACC-1:0] rnd;
    logic signed [W_OUT-1:0] sat;

    // T[r][k]: the angle (2r+1)k*pi/16 is folded into [0, pi/2] to pick a magnitude and sign.
    // k = 0 lands on index 0 and shares 5793 with index 4 because of the 1/sqrt(2) weight.
    function automatic logic signed [W_C-1:0] coef(input logic [2:0] r, input logic [2:0] k);
        int                    p;
        int                    j;
        logic                  neg;
        logic signed [W_C-1:0] mag;
        p   = ((2 * int'(r) + 1) * int'(k)) % 32;
        p   = p > 16 ? 32 - p : p;
        neg = p > 8;
        j   = neg ? 16 - p : p;
        mag = W_C'(j == 1 ? 8035 : j == 2 ? 7568 : j == 3 ? 6811 :
                   j == 5 ? 4551 : j == 6 ? 3135 : j == 7 ? 1598 : 5793);
        return neg ? -mag : mag;
    endfunction

    assign take = ena_in && !rst;
    assign last = take && in_cnt == 3'd7;

    always_comb begin
        acc = '0;
        for (int k = 0; k < 8; k++)
            acc = acc + W_ACC'(cur[k]) * W_ACC'(coef(n, 3'(k)));
        rnd = (acc + W_ACC'(1 << 13)) >>> 14;
        sat = rnd > hi_lim ? hi_lim[W_OUT-1:0] : rnd < lo_lim ? lo_lim[W_OUT-1:0] : rnd[W_OUT-1:0];
    end

    // The output stage reads cur, loaded when a row starts, so a following row copied into
    // work on the edge that enters RUN(7) cannot disturb the x[7] still being produced.
    always_ff @(posedge clk) begin
        if (take)
            col[in_cnt] <= S_in;
        if (last) begin
            for (int k = 0; k < 7; k++)
                work[k] <= col[k];
            work[7] <= S_in;
        end
        if (copied)
            cur <= work;
    end

    // A new row copy is always seen while in IDLE or RUN(7), since a row needs 8 accepts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_cnt    <= '0;
            n         <= '0;
            copied    <= 1'b0;
            state     <= IDLE;
            out_valid <= 1'b0;
            out_first <= 1'b0;
            S_out     <= '0;
        end else begin
            if (ena_in)
                in_cnt <= in_cnt + 3'd1;
            copied    <= last;
            out_valid <= state == RUN;
            out_first <= state == RUN && n == 3'd0;
            if (state == RUN)
                S_out <= sat;
            if (copied) begin
                state <= RUN;
                n     <= '0;
            end else if (state == RUN) begin
                n <= n + 3'd1;
                if (n == 3'd7)
                    state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_idct_1d.sv
// tb_idct_1d: directed and random checks of idct_1d against hand-computed rows and an
// integer T-matrix reference model.
module tb_idct_1d;
    logic              clk    = 1'b0;
    logic              rst    = 1'b1;
    logic              ena_in = 1'b0;
    logic signed [11:0] S_in  = '0;
    logic              out_valid;
    logic              out_first;
    logic signed [7:0] S_out;

    int cyc    = 0;
    int n_chk  = 0;
    int n_fail = 0;
    int got_q[$];
    int first_q[$];
    int cyc_q[$];
    int exp_q[$];
    int x0_q[$];
    int gap_q[$];
    int x_dc[8], e_dc[8], x_ac[8], e_ac[8], x_lo[8], e_lo[8], x_hi[8], e_hi[8];
    int xr[8], er[8];
    int budget;

    int t_mat [8][8] = '{
        '{5793,  8035,  7568,  6811,  5793,  4551,  3135,  1598},
        '{5793,  6811,  3135, -1598, -5793, -8035, -7568, -4551},
        '{5793,  4551, -3135, -8035, -5793,  1598,  7568,  6811},
        '{5793,  1598, -7568, -4551,  5793,  6811, -3135, -8035},
        '{5793, -1598, -7568,  4551,  5793, -6811, -3135,  8035},
        '{5793, -4551, -3135,  8035, -5793, -1598,  7568, -6811},
        '{5793, -6811,  3135,  1598, -5793,  8035, -7568,  4551},
        '{5793, -8035,  7568, -6811,  5793, -4551,  3135, -1598}
    };

    idct_1d dut (
        .clk(clk),
        .rst(rst),
        .ena_in(ena_in),
        .S_in(S_in),
        .out_valid(out_valid),
        .out_first(out_first),
        .S_out(S_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid) begin
            got_q.push_back(int'(S_out));
            first_q.push_back(int'(out_first));
            cyc_q.push_back(cyc);
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int model(input int x[8], input int n);
        longint s = 8192;
        for (int k = 0; k < 8; k++)
            s += longint'(t_mat[n][k]) * longint'(x[k]);
        s = s >>> 14;
        return s > 127 ? 127 : s < -128 ? -128 : int'(s);
    endfunction

    task automatic clear_q();
        got_q.delete();
        first_q.delete();
        cyc_q.delete();
        exp_q.delete();
        x0_q.delete();
        gap_q.delete();
    endtask

    task automatic put(input int v);
        @(negedge clk);
        ena_in = 1'b1;
        S_in   = 12'(v);
    endtask

    task automatic send_row(input int x[8], input int e[8], input int gaps);
        int ng = 0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0 && gaps[i]) begin
                @(negedge clk);
                ena_in = 1'b0;
                ng++;
            end
            put(x[i]);
            if (i == 0)
                x0_q.push_back(cyc + 1);
            exp_q.push_back(e[i]);
        end
        gap_q.push_back(ng);
    endtask

    task automatic drain(input string tag);
        int b = 0;
        @(negedge clk);
        ena_in = 1'b0;
        while (got_q.size() < exp_q.size() && b < 100) begin
            @(posedge clk);
            b++;
        end
        repeat (12) @(posedge clk);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s_val[%0d]", tag, i), got_q[i], exp_q[i]);
            check($sformatf("%s_first[%0d]", tag, i), first_q[i], int'(i % 8 == 0));
            if (i % 8 == 0)
                check($sformatf("%s_start[%0d]", tag, i), cyc_q[i] - x0_q[i / 8], 9 + gap_q[i / 8]);
            else
                check($sformatf("%s_run[%0d]", tag, i), cyc_q[i] - cyc_q[i - 1], 1);
        end
        clear_q();
    endtask

    task automatic hit_rst(input string tag);
        @(negedge clk);
        ena_in = 1'b0;
        #2 rst = 1'b1;
        #1;
        check({tag, "_valid"}, int'(out_valid), 0);
        check({tag, "_first"}, int'(out_first), 0);
        check({tag, "_data"}, int'(S_out), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_q();
        repeat (12) @(posedge clk);
        check({tag, "_no_resume"}, got_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        x_dc = '{64, 0, 0, 0, 0, 0, 0, 0};
        e_dc = '{23, 23, 23, 23, 23, 23, 23, 23};
        x_ac = '{0, 100, 0, 0, 0, 0, 0, 0};
        e_ac = '{49, 42, 28, 10, -10, -28, -42, -49};
        x_lo = '{-2048, 0, 0, 0, 0, 0, 0, 0};
        e_lo = '{-128, -128, -128, -128, -128, -128, -128, -128};
        x_hi = '{2047, 0, 0, 0, 0, 0, 0, 0};
        e_hi = '{127, 127, 127, 127, 127, 127, 127, 127};

        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", int'(out_valid), 0);
        check("reset_first", int'(out_first), 0);
        check("reset_data", int'(S_out), 0);
        @(negedge clk);
        rst = 1'b0;

        send_row(x_dc, e_dc, 0);
        drain("dc");
        send_row(x_ac, e_ac, 0);
        drain("ac1");
        send_row(x_lo, e_lo, 0);
        drain("sat_lo");
        send_row(x_hi, e_hi, 0);
        drain("sat_hi");

        send_row(x_dc, e_dc, 0);
        send_row(x_ac, e_ac, 0);
        send_row(x_lo, e_lo, 0);
        drain("b2b");

        send_row(x_ac, e_ac, int'($urandom & 32'hFE));
        send_row(x_hi, e_hi, int'($urandom & 32'hFE));
        send_row(x_dc, e_dc, 32'hAA);
        drain("gaps");

        send_row(x_dc, e_dc, 0);
        put(500);
        put(-300);
        put(200);
        put(100);
        check("pre_rst_valid", int'(out_valid), 1);
        hit_rst("rst_row");
        send_row(x_ac, e_ac, 0);
        drain("post_rst");

        send_row(x_hi, e_hi, 0);
        @(negedge clk);
        ena_in = 1'b0;
        budget = 0;
        while (got_q.size() < 4 && budget < 50) begin
            @(posedge clk);
            budget++;
        end
        check("rst_out_reached", int'(got_q.size() >= 4), 1);
        hit_rst("rst_out");

        for (int r = 0; r < 1000; r++) begin
            for (int k = 0; k < 8; k++)
                xr[k] = int'($urandom_range(4095)) - 2048;
            for (int k = 0; k < 8; k++)
                er[k] = model(xr, k);
            send_row(xr, er, $urandom_range(3) == 0 ? int'($urandom & 32'hFE) : 0);
        end
        drain("rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
